// File: rtl/alpha_mem_pkg.sv
// Shared types and default widths for the alphacore memory port arbiter.
package alpha_mem_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store,
// LS first with a starvation override for IF, and routes read data back to its owner.
//
// rsp state | meaning
// RSP_NONE  | no read response due this cycle
// RSP_IF    | mem_rdata belongs to instruction fetch
// RSP_LS    | mem_rdata belongs to load/store
module mem_port_arbiter
  import alpha_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  rsp_owner_t rsp_q, rsp_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       if_starved;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_starved = if_req && (wait_cnt_q >= MAX_WAIT_C);
    if (rst_n) begin
      if (ls_req && !if_starved) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = ls_gnt & ls_we;
    mem_be    = (ls_gnt && ls_we) ? ls_be : '1;
    mem_addr  = ls_gnt ? ls_addr : if_addr;
    mem_wdata = ls_wdata;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req || if_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Writes never produce a response, so only read grants claim the next cycle.
  always_comb begin
    rsp_d = RSP_NONE;
    if (if_gnt) begin
      rsp_d = RSP_IF;
    end else if (ls_gnt && !ls_we) begin
      rsp_d = RSP_LS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q      <= RSP_NONE;
      wait_cnt_q <= 4'd0;
    end else begin
      rsp_q      <= rsp_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign if_rvalid = (rsp_q == RSP_IF);
  assign ls_rvalid = (rsp_q == RSP_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a behavioural byte-enable RAM.
module tb_mem_port_arbiter;

  localparam logic [31:0] W0 = 32'h000006b3;
  localparam logic [31:0] W1 = 32'h00600713;
  localparam logic [31:0] W2 = 32'h00c00793;
  localparam logic [31:0] W3 = 32'h00f707b3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [7:0]  if_addr, ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] ram [256];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM image is (re)loaded while reset is held; addresses touched later are not reused after a mid-run reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[0]     <= W0;
      ram[1]     <= W1;
      ram[2]     <= W2;
      ram[3]     <= W3;
      ram[8'h30] <= 32'h11223344;
      mem_rdata  <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  typedef struct {
    logic        if_req;
    logic [7:0]  if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic        e_if_rv;
    logic        e_ls_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [7:0] ia, input logic lr, input logic we,
                     input logic [7:0] la, input logic [31:0] wd, input logic [3:0] be,
                     input logic eig, input logic elg, input logic eirv, input logic elrv,
                     input logic [31:0] erd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = we; v.ls_addr = la;
    v.ls_wdata = wd; v.ls_be = be; v.e_if_gnt = eig; v.e_ls_gnt = elg;
    v.e_if_rv = eirv; v.e_ls_rv = elrv; v.e_rdata = erd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b1; if_addr = 8'h00;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h40; ls_wdata = 32'h0; ls_be = 4'hF;

    // Reset held with both requests pending: nothing may reach the RAM.
    @(negedge clk); @(negedge clk); #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);

    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("rel_if_gnt", 32'(if_gnt), 32'd0);
    chk("rel_mem_we", 32'(mem_we), 32'd1);

    //  ir  ia     lr  we  la     wdata          be     eig elg eirv elrv erd
    add(1, 8'h00, 0, 0, 8'h00, 32'h0,         4'h0, 1, 0, 0, 0, 32'h0);
    add(1, 8'h01, 0, 0, 8'h00, 32'h0,         4'h0, 1, 0, 1, 0, W0);
    add(1, 8'h02, 0, 0, 8'h00, 32'h0,         4'h0, 1, 0, 1, 0, W1);
    add(1, 8'h03, 0, 0, 8'h00, 32'h0,         4'h0, 1, 0, 1, 0, W2);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         4'h0, 0, 0, 1, 0, W3);
    add(0, 8'h00, 1, 1, 8'h21, 32'h00000007,  4'hF, 0, 1, 0, 0, 32'h0);
    add(0, 8'h00, 1, 0, 8'h21, 32'h0,         4'h0, 0, 1, 0, 0, 32'h0);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         4'h0, 0, 0, 0, 1, 32'h00000007);
    add(0, 8'h00, 1, 1, 8'h30, 32'hAABBCCDD,  4'h1, 0, 1, 0, 0, 32'h0);
    add(0, 8'h00, 1, 0, 8'h30, 32'h0,         4'h0, 0, 1, 0, 0, 32'h0);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         4'h0, 0, 0, 0, 1, 32'h112233DD);
    add(0, 8'h00, 1, 1, 8'h30, 32'hFFFFFFFF,  4'h0, 0, 1, 0, 0, 32'h0);
    add(0, 8'h00, 1, 0, 8'h30, 32'h0,         4'h0, 0, 1, 0, 0, 32'h0);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         4'h0, 0, 0, 0, 1, 32'h112233DD);
    // Both requesting: LS wins four times, then the starved IF gets one slot.
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 0, 32'h0);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 1, 0, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 1, 0, W0);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 0, 1, 0, 1, W1);
    add(1, 8'h00, 1, 0, 8'h01, 32'h0,         4'h0, 1, 0, 0, 1, W1);
    add(0, 8'h00, 0, 0, 8'h00, 32'h0,         4'h0, 0, 0, 1, 0, W0);

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      ls_req = vecs[i].ls_req; ls_we = vecs[i].ls_we; ls_addr = vecs[i].ls_addr;
      ls_wdata = vecs[i].ls_wdata; ls_be = vecs[i].ls_be;
      #1;
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d_ls_gnt", i), 32'(ls_gnt), 32'(vecs[i].e_ls_gnt));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_if_gnt | vecs[i].e_ls_gnt));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_ls_gnt & vecs[i].ls_we));
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_if_rv));
      chk($sformatf("v%0d_ls_rvalid", i), 32'(ls_rvalid), 32'(vecs[i].e_ls_rv));
      if (vecs[i].e_if_rv) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_ls_rv) chk($sformatf("v%0d_ls_rdata", i), ls_rdata, vecs[i].e_rdata);
      if (vecs[i].e_ls_gnt) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].ls_addr));
      if (vecs[i].e_if_gnt) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].if_addr));
      if (vecs[i].e_ls_gnt && vecs[i].ls_we)
        chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].ls_be));
      if (vecs[i].e_if_gnt) chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'hF);
    end

    // Reset right after an IF read grant must drop the pending response.
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h02; ls_req = 1'b0; ls_we = 1'b0;
    #1 chk("mid_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("mid_rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    if_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    chk("post_rel_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("post_rel_ls_rvalid", 32'(ls_rvalid), 32'd0);
    @(negedge clk); #1;
    chk("post_rel2_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("post_rel2_ls_rvalid", 32'(ls_rvalid), 32'd0);

    // Back in service after reset: a fresh IF read returns data one cycle later.
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h03;
    #1 chk("again_if_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk);
    if_req = 1'b0; #1;
    chk("again_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("again_if_rdata", if_rdata, W3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
